// File: rtl/pipe_spawn_scheduler_if.sv
// Handshake bundle between the pipe spawn scheduler and its neighbours.
// Optional SPAWN_COUNT_EN adds the spawn_count field.
interface pipe_spawn_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic                 run;
    logic                 tick;
    logic [3:0]           rnd;
    logic [NUM_SLOTS-1:0] slot_free;
    logic                 spawn_ack;
    logic                 spawn_valid;
    logic [SW-1:0]        spawn_slot;
    logic [3:0]           spawn_gap;
    logic                 busy;
`ifdef SPAWN_COUNT_EN
    logic [7:0]           spawn_count;

    modport master (
        input  run, tick, rnd, slot_free, spawn_ack,
        output spawn_valid, spawn_slot, spawn_gap, busy, spawn_count
    );
    modport slave (
        output run, tick, rnd, slot_free, spawn_ack,
        input  spawn_valid, spawn_slot, spawn_gap, busy, spawn_count
    );
`else
    modport master (
        input  run, tick, rnd, slot_free, spawn_ack,
        output spawn_valid, spawn_slot, spawn_gap, busy
    );
    modport slave (
        output run, tick, rnd, slot_free, spawn_ack,
        input  spawn_valid, spawn_slot, spawn_gap, busy
    );
`endif
endinterface

// File: rtl/pipe_spawn_scheduler.sv
// Pipe spawn scheduler: counts ticks, shapes a random gap row, offers it to the lowest free slot.
// Optional macro SPAWN_COUNT_EN adds a saturating 8-bit accepted-spawn counter.
module pipe_spawn_scheduler #(
    parameter int SPAWN_INTERVAL = 8,
    parameter int NUM_SLOTS      = 4,
    parameter int GAP_MIN        = 2,
    parameter int GAP_MAX        = 11,
    parameter int MAX_STEP       = 3
) (
    input  logic      clk,
    input  logic      reset,
    pipe_spawn_if.master bus
);
    localparam int         SW       = $clog2(NUM_SLOTS);
    localparam int         CW       = $clog2(SPAWN_INTERVAL + 1);
    localparam logic [4:0] L_MIN    = 5'(GAP_MIN);
    localparam logic [4:0] L_MAX    = 5'(GAP_MAX);
    localparam logic [4:0] L_STEP   = 5'(MAX_STEP);
    localparam logic [3:0] GAP_INIT = 4'((GAP_MIN + GAP_MAX) / 2);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        SAMPLE,
        WAIT_SLOT,
        OFFER
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_prev_gap;
    logic [3:0]    r_gap;
    logic [SW-1:0] r_slot;

    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_load_gap;
    logic          w_load_slot;
    logic          w_accept;
    logic          w_any_free;
    logic [SW-1:0] w_sel;
    logic          w_found;
    logic [4:0]    w_rnd5;
    logic [4:0]    w_prev5;
    logic [4:0]    w_clamp;
    logic [3:0]    w_shaped;

    assign w_any_free = |bus.slot_free;

    // Lowest-indexed free slot wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (bus.slot_free[i] && !w_found) begin
                w_sel   = SW'(i);
                w_found = 1'b1;
            end
        end
    end

    // Clamp into the legal band, then limit the step from the previous gap (5-bit, no wrap).
    always_comb begin
        w_rnd5  = {1'b0, bus.rnd};
        w_prev5 = {1'b0, r_prev_gap};
        if (w_rnd5 < L_MIN)
            w_clamp = L_MIN;
        else if (w_rnd5 > L_MAX)
            w_clamp = L_MAX;
        else
            w_clamp = w_rnd5;

        if (w_clamp > w_prev5 + L_STEP)
            w_shaped = 4'(w_prev5 + L_STEP);
        else if (w_clamp + L_STEP < w_prev5)
            w_shaped = 4'(w_prev5 - L_STEP);
        else
            w_shaped = 4'(w_clamp);
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_load_gap  = 1'b0;
        w_load_slot = 1'b0;
        w_accept    = 1'b0;
        if (!bus.run) begin
            w_next    = IDLE;
            w_cnt_clr = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_next    = COUNT;
                    w_cnt_clr = 1'b1;
                end
                COUNT: begin
                    if (bus.tick) begin
                        if (r_cnt == CW'(SPAWN_INTERVAL - 1)) begin
                            w_cnt_clr = 1'b1;
                            w_next    = SAMPLE;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    w_load_gap = 1'b1;
                    if (w_any_free) begin
                        w_next      = OFFER;
                        w_load_slot = 1'b1;
                    end else begin
                        w_next = WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (w_any_free) begin
                        w_next      = OFFER;
                        w_load_slot = 1'b1;
                    end
                end
                OFFER: begin
                    if (bus.spawn_ack) begin
                        w_accept  = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = COUNT;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prev_gap <= GAP_INIT;
            r_gap      <= '0;
            r_slot     <= '0;
        end else begin
            r_state <= w_next;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + 1'b1;
            // Dropping run restarts the gap walk even if an ack arrives in the same cycle.
            if (!bus.run)
                r_prev_gap <= GAP_INIT;
            else if (w_accept)
                r_prev_gap <= r_gap;
            if (w_load_gap)
                r_gap <= w_shaped;
            if (w_load_slot)
                r_slot <= w_sel;
        end
    end

    assign bus.spawn_valid = (r_state == OFFER);
    assign bus.busy        = (r_state != IDLE);
    assign bus.spawn_slot  = r_slot;
    assign bus.spawn_gap   = r_gap;

`ifdef SPAWN_COUNT_EN
    logic [7:0] r_spawn_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_spawn_count <= '0;
        else if (bus.spawn_valid && bus.spawn_ack && (r_spawn_count != 8'hFF))
            r_spawn_count <= r_spawn_count + 8'd1;
    end

    assign bus.spawn_count = r_spawn_count;
`endif
endmodule
